uart_file_xfer: RTL
===================

# uart_file_xfer

Parametrised host-file transfer engine for the MNIST accelerator: on a `start` request it runs the host R/W protocol over the `rs232` block (header byte, file index, data bytes) and moves data to or from a byte-wide on-chip buffer through a synchronous memory port. It replaces the inline IO/SEND_HEAD/READ_GET_BYTE states of the top-level FSM, so convolution and maxpool stages request transfers through a start/done handshake.

## Interface
- `ADDR_W`, 16, buffer byte-address width
- `IDX_BYTES`, 2, number of file-index bytes sent, LSB first (1..4)
- `RX_TIMEOUT`, 1000000, clk cycles allowed between received bytes; 0 disables timeout

- `clk`  in  1  system clock (one clock domain)
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  transfer request, sampled in IDLE only
- `rw`  in  1  1 = READ (host→buffer, header 'R'), 0 = WRITE (buffer→host, header 'W')
- `file_index`  in  8*IDX_BYTES  file number sent to host
- `mem_start`, `mem_end`  in  ADDR_W each  inclusive buffer byte range
- `busy`  out  1  transfer in progress
- `done`  out  1  one-cycle completion pulse (success or error)
- `error`  out  1  last transfer failed; held until next accepted `start`
- `tx_data`  out  8  byte to `rs232`
- `tx_en`  out  1  one-cycle send strobe
- `tx_busy`  in  1  `rs232` transmitter busy
- `rx_data`  in  8  received byte
- `rx_rdy`  in  1  one-cycle pulse, `rx_data` valid
- `mem_addr`  out  ADDR_W  buffer address
- `mem_wdata`  out  8  write data
- `mem_we`  out  1  write strobe
- `mem_rdata`  in  8  read data, valid one cycle after `mem_addr`

## Operation
- States: IDLE, SEND_HDR, SEND_IDX, TX_WAIT, RX_BYTE, TX_FETCH, TX_BYTE, CHECK, FINISH.
- IDLE: on `start`, latch `rw`, `file_index`, `mem_start`, `mem_end`; clear `error`; go SEND_HDR. If `mem_end < mem_start`: set `error`, go FINISH (nothing sent).
- SEND_HDR: when `!tx_busy`, drive 0x52 ('R') or 0x57 ('W') with `tx_en`=1 one cycle → TX_WAIT, return SEND_IDX.
- SEND_IDX: send `IDX_BYTES` bytes LSB first, each via TX_WAIT; then pointer ← `mem_start`, go RX_BYTE (READ) or TX_FETCH (WRITE).
- TX_WAIT: wait for `tx_busy` high then low (byte consumed); return to saved state.
- RX_BYTE: on `rx_rdy`, `mem_we`=1, `mem_addr`=pointer, `mem_wdata`=`rx_data`; pointer+1. After byte at `mem_end` → CHECK.
- TX_FETCH: drive `mem_addr`=pointer → TX_BYTE. TX_BYTE: when `!tx_busy`, send `mem_rdata` → TX_WAIT, return TX_FETCH with pointer+1, or CHECK after `mem_end`.
- CHECK: see Configuration; otherwise pass straight to FINISH.
- FINISH: `done`=1 one cycle → IDLE.
- Pointer is ADDR_W+1 bits internally; `mem_end` = all-ones terminates correctly without wrap.
- `rx_rdy` outside RX_BYTE/CHECK-receive is ignored; `start` while `busy` ignored.
- Timeout: counter clears on entry to RX_BYTE and on every `rx_rdy`; reaching `RX_TIMEOUT` sets `error`, → FINISH. Bytes already written stay written.

## Timing
- Reset: state IDLE; `busy`, `done`, `error`, `tx_en`, `mem_we` = 0; `tx_data`, `mem_addr`, `mem_wdata` = 0; timeout counter and pointer 0. Reset mid-transfer aborts immediately, no `done`.
- `busy` rises the cycle after `start` accepted, falls in the cycle `done` pulses.
- `tx_en` never asserted while `tx_busy`=1; `tx_data` stable only in the `tx_en` cycle.
- `rs232` asserts `tx_busy` the cycle after `tx_en`; TX_WAIT requires seeing it.
- RX write: `mem_we` in the same cycle as `rx_rdy` is sampled (registered output, next-edge write), one byte per `rx_rdy`.
- WRITE memory read latency 1 cycle (TX_FETCH→TX_BYTE).
- `rx_rdy` coincident with timeout terminal count: byte accepted, timeout suppressed.

## Configuration
- `UART_FILE_XFER_CHECKSUM_EN` defined: CHECK state active. WRITE: send 8-bit XOR of all data bytes as a trailer byte. READ: receive one extra byte (timeout applies); mismatch with XOR of data bytes sets `error`. Header and index excluded from checksum.
- Undefined: no trailer sent or expected; CHECK is a pass-through; checksum logic absent.

## Test plan
- READ, index 0x0005, range 0..3, host returns 11 22 33 44 → TX bytes 52 05 00; buffer[0..3]=11 22 33 44; `done` pulse, `error`=0.
- WRITE, index 0x0041, range 0x10..0x11 holding AA 55 → TX 57 41 00 AA 55 (+FF trailer with macro); no `mem_we`.
- READ with RX_TIMEOUT=100, host sends 2 of 4 bytes → `error`=1, `done` ~100 cycles after last byte; buffer holds 2 bytes.
- `mem_start`=8, `mem_end`=7 → `done` within 2 cycles, `error`=1, no `tx_en`.
- With macro, READ 01 02 then trailer 04 (expected 03) → `error`=1; trailer 03 → `error`=0.
- `reset` asserted during TX_WAIT → next cycle IDLE, all outputs 0; subsequent `start` runs normally.

Source files
------------

// File: rtl/uart_file_xfer.sv
// rtl/uart_file_xfer.sv - host file transfer engine (header, index, data) over rs232 to a byte buffer
// Define UART_FILE_XFER_CHECKSUM_EN to append/verify an XOR trailer byte after the data.
module uart_file_xfer #(
  parameter int ADDR_W     = 16,
  parameter int IDX_BYTES  = 2,
  parameter int RX_TIMEOUT = 1000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   rw,
  input  logic [8*IDX_BYTES-1:0] file_index,
  input  logic [ADDR_W-1:0]      mem_start,
  input  logic [ADDR_W-1:0]      mem_end,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [7:0]             tx_data,
  output logic                   tx_en,
  input  logic                   tx_busy,
  input  logic [7:0]             rx_data,
  input  logic                   rx_rdy,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [7:0]             mem_wdata,
  output logic                   mem_we,
  input  logic [7:0]             mem_rdata
);
  localparam int TMO_W = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = (RX_TIMEOUT > 0) ? TMO_W'(RX_TIMEOUT - 1) : '0;

  typedef enum logic [3:0] {
    IDLE, SEND_HDR, SEND_IDX, TX_WAIT, RX_BYTE, TX_FETCH, TX_BYTE, CHECK, FINISH
  } state_t;

  state_t                 state, ret_state;
  logic                   is_read;
  logic [8*IDX_BYTES-1:0] idx_sr;
  logic [2:0]             idx_cnt;
  logic [ADDR_W:0]        ptr, end_ptr, ptr_nxt;
  logic                   tx_seen;
  logic [TMO_W-1:0]       tmo_cnt;
  logic                   tmo_hit;
`ifdef UART_FILE_XFER_CHECKSUM_EN
  logic [7:0]             csum;
`endif

  // One extra pointer bit lets a range ending at the top address terminate without wrapping.
  assign ptr_nxt = ptr + 1'b1;
  assign tmo_hit = (RX_TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ret_state <= IDLE;
      is_read   <= 1'b0;
      idx_sr    <= '0;
      idx_cnt   <= '0;
      ptr       <= '0;
      end_ptr   <= '0;
      tx_seen   <= 1'b0;
      tmo_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      tx_data   <= '0;
      tx_en     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
`ifdef UART_FILE_XFER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      tx_en  <= 1'b0;
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy    <= 1'b1;
          is_read <= rw;
          idx_sr  <= file_index;
          ptr     <= {1'b0, mem_start};
          end_ptr <= {1'b0, mem_end};
`ifdef UART_FILE_XFER_CHECKSUM_EN
          csum    <= '0;
`endif
          if (mem_end < mem_start) begin
            error <= 1'b1;
            state <= FINISH;
          end else begin
            error <= 1'b0;
            state <= SEND_HDR;
          end
        end
        SEND_HDR: if (!tx_busy) begin
          tx_en     <= 1'b1;
          tx_data   <= is_read ? 8'h52 : 8'h57;
          idx_cnt   <= '0;
          ret_state <= SEND_IDX;
          state     <= TX_WAIT;
        end
        SEND_IDX: begin
          if (idx_cnt == 3'(IDX_BYTES)) begin
            // Address goes out now so the first read byte is ready by TX_BYTE.
            mem_addr <= ptr[ADDR_W-1:0];
            tmo_cnt  <= '0;
            state    <= is_read ? RX_BYTE : TX_FETCH;
          end else if (!tx_busy) begin
            tx_en     <= 1'b1;
            tx_data   <= idx_sr[7:0];
            idx_sr    <= idx_sr >> 8;
            idx_cnt   <= idx_cnt + 3'd1;
            ret_state <= SEND_IDX;
            state     <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (tx_busy) begin
            tx_seen <= 1'b1;
          end else if (tx_seen) begin
            tx_seen <= 1'b0;
            state   <= ret_state;
          end
        end
        RX_BYTE: begin
          if (rx_rdy) begin
            mem_we    <= 1'b1;
            mem_addr  <= ptr[ADDR_W-1:0];
            mem_wdata <= rx_data;
            ptr       <= ptr_nxt;
            tmo_cnt   <= '0;
`ifdef UART_FILE_XFER_CHECKSUM_EN
            csum      <= csum ^ rx_data;
`endif
            if (ptr == end_ptr) state <= CHECK;
          end else if (tmo_hit) begin
            error <= 1'b1;
            state <= FINISH;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        TX_FETCH: begin
          mem_addr <= ptr[ADDR_W-1:0];
          state    <= TX_BYTE;
        end
        TX_BYTE: if (!tx_busy) begin
          tx_en     <= 1'b1;
          tx_data   <= mem_rdata;
`ifdef UART_FILE_XFER_CHECKSUM_EN
          csum      <= csum ^ mem_rdata;
`endif
          ptr       <= ptr_nxt;
          mem_addr  <= ptr_nxt[ADDR_W-1:0];
          ret_state <= (ptr == end_ptr) ? CHECK : TX_FETCH;
          state     <= TX_WAIT;
        end
        CHECK: begin
`ifdef UART_FILE_XFER_CHECKSUM_EN
          if (is_read) begin
            if (rx_rdy) begin
              if (rx_data != csum) error <= 1'b1;
              state <= FINISH;
            end else if (tmo_hit) begin
              error <= 1'b1;
              state <= FINISH;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end else if (!tx_busy) begin
            tx_en     <= 1'b1;
            tx_data   <= csum;
            ret_state <= FINISH;
            state     <= TX_WAIT;
          end
`else
          state <= FINISH;
`endif
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
